ssd_scanner: RTL and testbench

Parametrised multiplexed seven-segment scan controller that drives DIGITS common-anode digits from one clock. It replaces externally supplied scan-phase inputs with an internal slot counter and adds:
- a frame snapshot of the input digits, so a frame never tears;
- dead-time anode blanking against ghosting;
- per-digit decimal point and blink masks.

It sits between the game/score logic and the BCD-to-segment decoder on the board's display pins.

---
 rtl/ssd_pkg.sv | 11 +
 rtl/ssd_slot_timer.sv | 73 +++++++
 rtl/ssd_scanner.sv | 115 +++++++++++
 tb/tb_ssd_scanner.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared widths and pin polarities for the seven-segment scanner
package ssd_pkg;

  localparam int SSD_DIGIT_W = 4;

  // Common-anode board: anodes and decimal point are active low.
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON  = 1'b0;
  localparam logic DP_OFF    = 1'b1;

endpackage

// File: rtl/ssd_slot_timer.sv
// rtl/ssd_slot_timer.sv - slot counter and digit index for the scan controller
// Marks frame starts (including the first enabled edge) and the dark part of each slot.
module ssd_slot_timer #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 1000,
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CNT_W   = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             slot_start_o,
  output logic             frame_start_o,
  output logic             dead_active_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             run_q, run_d;

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    run_d         = run_q;
    slot_start_o  = 1'b0;
    frame_start_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      idx_d = IDX_LAST;
      run_d = 1'b0;
    end else if (!run_q) begin
      // First enabled edge restarts the scan at the most significant digit.
      cnt_d         = '0;
      idx_d         = IDX_LAST;
      run_d         = 1'b1;
      slot_start_o  = 1'b1;
      frame_start_o = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d        = '0;
      slot_start_o = 1'b1;
      if (idx_q == '0) begin
        idx_d         = IDX_LAST;
        frame_start_o = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= IDX_LAST;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

  assign idx_o         = idx_q;
  // Idle (not yet started) counts as dark so nothing lights before the first snapshot.
  assign dead_active_o = !run_q || (int'(cnt_q) < DEAD);

endmodule

// File: rtl/ssd_scanner.sv
// rtl/ssd_scanner.sv - multiplexed seven-segment scan controller with snapshot, dead time and blink
// Optional leading-zero blanking when SSD_LZ_BLANK_EN is defined.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 1000,
  parameter int BLINK_FRAMES = 64,
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int FCNT_W      = $clog2(BLINK_FRAMES) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [SSD_DIGIT_W*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]             dp_mask,
  input  logic [DIGITS-1:0]             blink_mask,
  output logic [SSD_DIGIT_W-1:0]        ssd_output,
  output logic [DIGITS-1:0]             ssd_ctl,
  output logic                          ssd_dp
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [IDX_W-1:0] idx;
  logic             frame_start, dead_active, slot_start_unused;

  logic [DIGITS-1:0][SSD_DIGIT_W-1:0] dig_q;
  logic [DIGITS-1:0]                  dpm_q, blm_q, lz_blank;
  logic [FCNT_W-1:0]                  fcnt_q;
  logic                               blink_q;

  logic [SSD_DIGIT_W-1:0] out_d, out_q;
  logic [DIGITS-1:0]      ctl_d, ctl_q;
  logic                   dp_d, dp_q, suppress, lit;

  ssd_slot_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DEAD     (DEAD)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .idx_o         (idx),
    .slot_start_o  (slot_start_unused),
    .frame_start_o (frame_start),
    .dead_active_o (dead_active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      dpm_q   <= '0;
      blm_q   <= '0;
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (frame_start) begin
      dig_q <= digits;
      dpm_q <= dp_mask;
      blm_q <= blink_mask;
      if (fcnt_q == FCNT_LAST) begin
        fcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

`ifdef SSD_LZ_BLANK_EN
  logic lz_run;

  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run && (dig_q[i] == '0);
      lz_blank[i] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    suppress = (blink_q & blm_q[idx]) | lz_blank[idx];
    // en is folded in here so the display goes dark on the very edge that sees it low.
    lit      = en & ~dead_active & ~suppress;
    ctl_d    = {DIGITS{ANODE_OFF}};
    if (lit) begin
      ctl_d[idx] = ANODE_ON;
    end
    dp_d  = lit ? ~dpm_q[idx] : DP_OFF;
    out_d = dig_q[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ctl_q <= {DIGITS{ANODE_OFF}};
      dp_q  <= DP_OFF;
    end else begin
      out_q <= out_d;
      ctl_q <= ctl_d;
      dp_q  <= dp_d;
    end
  end

  assign ssd_output = out_q;
  assign ssd_ctl    = ctl_q;
  assign ssd_dp     = dp_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// tb/tb_ssd_scanner.sv - scoreboard bench for ssd_scanner (DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2)
module tb_ssd_scanner;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEAD     = 2;
  localparam int BF       = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  ssd_output;
  logic [3:0]  ssd_ctl;
  logic        ssd_dp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  // Reference model: position within the frame and frames seen since reset.
  bit          m_run;
  int          m_pos;
  int          m_nf;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_bl;

  ssd_scanner #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .DEAD         (DEAD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .ssd_output (ssd_output),
    .ssd_ctl    (ssd_ctl),
    .ssd_dp     (ssd_dp)
  );

  always #5 clk = ~clk;

  function automatic bit lz_blank(int d);
    bit blank = 1'b0;
`ifdef SSD_LZ_BLANK_EN
    if (d > 0) begin
      blank = 1'b1;
      for (int j = d; j < DIGITS; j++) begin
        if (m_dig[4*j +: 4] != 4'h0) blank = 1'b0;
      end
    end
`else
    blank = (d < 0);
`endif
    return blank;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_nf  = 0;
    m_dig = '0;
    m_dp  = '0;
    m_bl  = '0;
    exp_q.delete();
  endtask

  // Push the expected output for the coming edge, clock it, advance the model, sample point.
  task automatic cycle();
    int         d;
    bit         ph;
    bit         lit;
    logic [3:0] ctl;
    d   = m_run ? (DIGITS - 1 - m_pos / SCAN_DIV) : (DIGITS - 1);
    ph  = ((m_nf / BF) % 2) == 1;
    lit = en && m_run && ((m_pos % SCAN_DIV) >= DEAD) && !(ph && m_bl[d]) && !lz_blank(d);
    ctl = lit ? ~(4'b0001 << d) : 4'b1111;
    exp_q.push_back({m_dig[4*d +: 4], ctl, lit ? ~m_dp[d] : 1'b1});
    @(posedge clk);
    if (!en) begin
      m_run = 1'b0;
    end else if (!m_run || m_pos == FRAME - 1) begin
      m_run = 1'b1;
      m_pos = 0;
      m_dig = digits;
      m_dp  = dp_mask;
      m_bl  = blink_mask;
      m_nf++;
    end else begin
      m_pos++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ssd_output, ssd_ctl, ssd_dp} !== {4'h0, 4'b1111, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got %h/%b/%b want 0/1111/1", ssd_output, ssd_ctl, ssd_dp);
    end
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_scan();
    logic [8:0] e;
    logic [3:0] ctl_tab [16] = '{4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7,
                                 4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB};
    logic [3:0] want_out;
    do_reset();
    digits = 16'h1234;
    en     = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL scan k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
      if ((k >= 1 && k <= 16) || (k >= 33 && k <= 48)) begin
        want_out = (((k - 1) % FRAME) < 8) ? 4'd1 : 4'd2;
        n_checks++;
        if (ssd_ctl !== ctl_tab[(k - 1) % FRAME] || ssd_output !== want_out) begin
          n_fail++;
          $display("FAIL scan_pattern k=%0d got ctl=%b out=%h want ctl=%b out=%h", k, ssd_ctl, ssd_output, ctl_tab[(k - 1) % FRAME], want_out);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [8:0] e;
    do_reset();
    digits = 16'h1234;
    en     = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      if (k == 10) digits = 16'h5678;
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL snapshot k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
      if (k == 20 || k == 52) begin
        n_checks++;
        if (ssd_output !== ((k == 20) ? 4'd3 : 4'd7)) begin
          n_fail++;
          $display("FAIL snapshot_value k=%0d got %h want %h", k, ssd_output, (k == 20) ? 4'd3 : 4'd7);
        end
      end
    end
  endtask

  task automatic test_dp_blink();
    logic [8:0] e;
    int         lit0 [5];
    int         dpc  [5];
    int         f;
    for (int i = 0; i < 5; i++) begin
      lit0[i] = 0;
      dpc[i]  = 0;
    end
    do_reset();
    digits     = 16'h1234;
    dp_mask    = 4'b0010;
    blink_mask = 4'b0001;
    en         = 1'b1;
    for (int k = 0; k <= 5 * FRAME; k++) begin
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL dp_blink k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
      if (k >= 1) begin
        f = (k - 1) / FRAME;
        if (ssd_ctl === 4'b1110) lit0[f]++;
        if (ssd_dp === 1'b0) dpc[f]++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (lit0[i] != ((i == 1 || i == 2) ? 0 : 6) || dpc[i] != 6) begin
        n_fail++;
        $display("FAIL blink_frame frame=%0d got lit0=%0d dp=%0d want lit0=%0d dp=6", i + 1, lit0[i], dpc[i], (i == 1 || i == 2) ? 0 : 6);
      end
    end
    dp_mask    = '0;
    blink_mask = '0;
  endtask

  task automatic test_enable();
    logic [8:0] e;
    do_reset();
    digits = 16'h1234;
    en     = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      if (k == 13) en = 1'b0;
      if (k == 15) digits = 16'h9876;
      if (k == 18) en = 1'b1;
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL enable k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
      if (k >= 13 && k <= 20) begin
        n_checks++;
        if (ssd_ctl !== 4'b1111 || ssd_dp !== 1'b1) begin
          n_fail++;
          $display("FAIL enable_dark k=%0d got ctl=%b dp=%b want 1111/1", k, ssd_ctl, ssd_dp);
        end
      end
      if (k == 21) begin
        n_checks++;
        if (ssd_ctl !== 4'b0111 || ssd_output !== 4'h9) begin
          n_fail++;
          $display("FAIL enable_restart got ctl=%b out=%h want 0111/9", ssd_ctl, ssd_output);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [8:0] e;
    int         litc [4];
    int         want;
    for (int i = 0; i < 4; i++) litc[i] = 0;
    do_reset();
    digits = 16'h0070;
    en     = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL lz k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
      for (int i = 0; i < 4; i++) begin
        if (ssd_ctl[i] === 1'b0) litc[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
`ifdef SSD_LZ_BLANK_EN
      want = (i >= 2) ? 0 : 6;
`else
      want = 6;
`endif
      n_checks++;
      if (litc[i] != want) begin
        n_fail++;
        $display("FAIL lz_count digit=%0d got %0d want %0d", i, litc[i], want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    do_reset();
    digits = 16'h1234;
    en     = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ssd_output, ssd_ctl, ssd_dp} !== {4'h0, 4'b1111, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset got %h/%b/%b want 0/1111/1", ssd_output, ssd_ctl, ssd_dp);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      cycle();
      e = exp_q.pop_front();
      n_checks++;
      if ({ssd_output, ssd_ctl, ssd_dp} !== e) begin
        n_fail++;
        $display("FAIL post_reset k=%0d got %h/%b/%b want %h/%b/%b", k, ssd_output, ssd_ctl, ssd_dp, e[8:5], e[4:1], e[0]);
      end
      if (k == 3) begin
        n_checks++;
        if (ssd_ctl !== 4'b0111 || ssd_output !== 4'h1) begin
          n_fail++;
          $display("FAIL post_reset_start got ctl=%b out=%h want 0111/1", ssd_ctl, ssd_output);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_dp_blink();
    test_enable();
    test_lz();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
